wb_simple_master: RTL and testbench
===================================

WB_SIMPLE_MASTER -- requirements
Module: wb_simple_master

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles STB may wait for ACK/ERR/RTY before abort; legal range 1..255.
REQ-002 Parameter MAX_RETRY, default 3: max reissues after RTY before abort; legal range 0..15.
REQ-003 p_clk  in  1  single clock; all state updates on rising edge.
REQ-004 p_resetn  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  local command request.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at rising edge.
REQ-007 cmd_we / cmd_adr / cmd_dat / cmd_sel  in  1/32/32/4  write flag, byte address, write data, byte lanes.
REQ-008 rsp_valid  out  1  response available; rsp_ready  in  1  response consumed.
REQ-009 rsp_dat / rsp_code  out  32/2  read data (0 for writes); 0=OK, 1=ERR, 2=TIMEOUT, 3=RETRY_EXHAUSTED.
REQ-010 p_wb_CYC_O, p_wb_STB_O, p_wb_WE_O  out  1 each; p_wb_ADR_O, p_wb_DAT_O  out  32; p_wb_SEL_O  out  4; p_wb_LOCK_O  out  1.
REQ-011 p_wb_DAT_I  in  32; p_wb_ACK_I, p_wb_ERR_I, p_wb_RTY_I  in  1 each.

Function
REQ-012 FSM states IDLE, BUS, BACKOFF, RESP; all outputs registered.
REQ-013 IDLE: cmd_ready=1; on accept, latch cmd_* into ADR/DAT/SEL/WE outputs, CYC=STB=1 from next cycle, go BUS.
REQ-014 cmd_ready SHALL be 0 in every state other than IDLE; no command queuing.
REQ-015 BUS: ADR/DAT/SEL/WE held stable while STB=1.
REQ-016 BUS, ERR_I=1 sampled: CYC=STB=0 next cycle, rsp_code=1, go RESP; ERR wins over simultaneous ACK or RTY.
REQ-017 BUS, ACK_I=1 (no ERR): CYC=STB=0 next cycle, rsp_dat=DAT_I if read else 0, rsp_code=0, go RESP.
REQ-018 BUS, RTY_I=1 (no ERR/ACK): if retries<MAX_RETRY, increment retries, CYC=STB=0 for exactly one cycle (BACKOFF), then reissue identical cycle; else rsp_code=3, go RESP.
REQ-019 Timeout counter cleared on each STB assertion, increments each BUS cycle without ACK/ERR/RTY; on reaching TIMEOUT: CYC=STB=0, rsp_code=2, go RESP.
REQ-020 Best-case latency: accept at edge N, STB high N+1, ACK sampled N+1, rsp_valid high N+2.
REQ-021 RESP: rsp_valid=1, rsp_dat/rsp_code stable until rsp_valid && rsp_ready; then IDLE with cmd_ready=1 next cycle.
REQ-022 ACK/ERR/RTY while CYC=0 SHALL be ignored.
REQ-023 p_wb_LOCK_O SHALL be constant 0.
REQ-024 Retry counter and timeout counter cleared on each accepted command.

Reset
REQ-025 p_resetn low SHALL asynchronously force IDLE, CYC=STB=WE=0, ADR=DAT=0, SEL=0, rsp_valid=0, rsp_dat=0, rsp_code=0, counters=0, cmd_ready=0 while in reset.
REQ-026 Reset mid-transaction SHALL drop CYC/STB immediately; the in-flight command is discarded with no response.
REQ-027 First command accepted no earlier than first rising edge after p_resetn deasserts.

Structure
REQ-028 Shared package wb_master_pkg holds state enum, rsp_code enum, and WB_ADDR_W=32/WB_DATA_W=32 constants.
REQ-029 Single module; no sub-module required.

Verification
REQ-030 Write 0xDEADBEEF to 0xb0000004, SEL=0xF, slave ACKs first cycle -> one STB cycle with WE=1, rsp_valid 2 cycles after accept, rsp_code=0.
REQ-031 Read 0xb0000000, slave ACKs after 3 wait cycles with 0x12345678 -> STB held 4 cycles, rsp_dat=0x12345678, rsp_code=0.
REQ-032 Slave RTY twice then ACK, MAX_RETRY=3 -> three STB cycles separated by one idle cycle each, rsp_code=0; with RTY forever -> 4 attempts, rsp_code=3.
REQ-033 Slave silent, TIMEOUT=16 -> STB drops after 16 cycles, rsp_code=2; ACK+ERR same cycle -> rsp_code=1.
REQ-034 p_resetn pulsed low during BUS -> CYC/STB low before next edge, no rsp_valid, next command completes normally; rsp_ready held low 5 cycles -> rsp stable, cmd_ready stays 0.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared types and bus widths for the simple Wishbone master.
package wb_master_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = WB_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS     = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RSP_OK        = 2'd0,
    RSP_ERR       = 2'd1,
    RSP_TIMEOUT   = 2'd2,
    RSP_RETRY_EXH = 2'd3
  } rsp_code_t;

endpackage

// File: rtl/wb_simple_master_if.sv
// Local command/response handshake plus Wishbone bus signals of the master.
interface wb_simple_master_if;
  import wb_master_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_we;
  logic [WB_ADDR_W-1:0] cmd_adr;
  logic [WB_DATA_W-1:0] cmd_dat;
  logic [WB_SEL_W-1:0]  cmd_sel;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WB_DATA_W-1:0] rsp_dat;
  logic [1:0]           rsp_code;

  logic                 p_wb_CYC_O;
  logic                 p_wb_STB_O;
  logic                 p_wb_WE_O;
  logic [WB_ADDR_W-1:0] p_wb_ADR_O;
  logic [WB_DATA_W-1:0] p_wb_DAT_O;
  logic [WB_SEL_W-1:0]  p_wb_SEL_O;
  logic                 p_wb_LOCK_O;
  logic [WB_DATA_W-1:0] p_wb_DAT_I;
  logic                 p_wb_ACK_I;
  logic                 p_wb_ERR_I;
  logic                 p_wb_RTY_I;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
           p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I, p_wb_RTY_I,
    output cmd_ready, rsp_valid, rsp_dat, rsp_code,
           p_wb_CYC_O, p_wb_STB_O, p_wb_WE_O, p_wb_ADR_O, p_wb_DAT_O,
           p_wb_SEL_O, p_wb_LOCK_O
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
           p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I, p_wb_RTY_I,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_code,
           p_wb_CYC_O, p_wb_STB_O, p_wb_WE_O, p_wb_ADR_O, p_wb_DAT_O,
           p_wb_SEL_O, p_wb_LOCK_O
  );

endinterface

// File: rtl/wb_simple_master.sv
// Single-outstanding Wishbone classic master with retry backoff and STB timeout.
import wb_master_pkg::*;

module wb_simple_master #(
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                p_clk,
  input  logic                p_resetn,
  wb_simple_master_if.master  bus
);

  state_t               r_state;
  logic                 r_cmd_ready;
  logic                 r_cyc;
  logic                 r_stb;
  logic                 r_we;
  logic [WB_ADDR_W-1:0] r_adr;
  logic [WB_DATA_W-1:0] r_dat;
  logic [WB_SEL_W-1:0]  r_sel;
  logic                 r_rsp_valid;
  logic [WB_DATA_W-1:0] r_rsp_dat;
  rsp_code_t            r_rsp_code;
  logic [3:0]           r_retry;
  logic [7:0]           r_tmo;

  logic w_accept;
  assign w_accept = bus.cmd_valid && r_cmd_ready;

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_code  <= RSP_OK;
      r_retry     <= '0;
      r_tmo       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_we        <= bus.cmd_we;
            r_adr       <= bus.cmd_adr;
            r_dat       <= bus.cmd_dat;
            r_sel       <= bus.cmd_sel;
            r_cyc       <= 1'b1;
            r_stb       <= 1'b1;
            r_retry     <= '0;
            r_tmo       <= '0;
            r_state     <= ST_BUS;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end

        // ERR > ACK > RTY > timeout; every exit except retry-backoff ends in RESP
        ST_BUS: begin
          if (bus.p_wb_ERR_I) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_code  <= RSP_ERR;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else if (bus.p_wb_ACK_I) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_dat   <= r_we ? '0 : bus.p_wb_DAT_I;
            r_rsp_code  <= RSP_OK;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else if (bus.p_wb_RTY_I) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            if (r_retry < 4'(MAX_RETRY)) begin
              r_retry <= r_retry + 4'd1;
              r_state <= ST_BACKOFF;
            end else begin
              r_rsp_dat   <= '0;
              r_rsp_code  <= RSP_RETRY_EXH;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end
          end else if (r_tmo == 8'(TIMEOUT - 1)) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_code  <= RSP_TIMEOUT;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end

        ST_BACKOFF: begin
          r_cyc   <= 1'b1;
          r_stb   <= 1'b1;
          r_tmo   <= '0;
          r_state <= ST_BUS;
        end

        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_dat     = r_rsp_dat;
  assign bus.rsp_code    = r_rsp_code;
  assign bus.p_wb_CYC_O  = r_cyc;
  assign bus.p_wb_STB_O  = r_stb;
  assign bus.p_wb_WE_O   = r_we;
  assign bus.p_wb_ADR_O  = r_adr;
  assign bus.p_wb_DAT_O  = r_dat;
  assign bus.p_wb_SEL_O  = r_sel;
  assign bus.p_wb_LOCK_O = 1'b0;

endmodule

// File: tb/tb_wb_simple_master.sv
// Directed bench for wb_simple_master: ACK, wait states, retry, timeout, ERR, reset.
module tb_wb_simple_master;
  import wb_master_pkg::*;

  logic p_clk    = 1'b0;
  logic p_resetn = 1'b0;
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  wb_simple_master_if bus ();

  wb_simple_master #(.TIMEOUT(16), .MAX_RETRY(3)) dut (
    .p_clk    (p_clk),
    .p_resetn (p_resetn),
    .bus      (bus)
  );

  always #5 p_clk = ~p_clk;

  task automatic step();
    @(posedge p_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    int unsigned n = 0;
    bus.cmd_we = we; bus.cmd_adr = adr; bus.cmd_dat = dat; bus.cmd_sel = sel;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 20) begin
      step();
      n++;
    end
    chk1("cmd_ready_wait", bus.cmd_ready, 1'b1);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic release_rsp(input string tag);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk1({tag, "_rsp_valid_clr"}, bus.rsp_valid, 1'b0);
    chk1({tag, "_cmd_ready_back"}, bus.cmd_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned attempts;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_adr = '0; bus.cmd_dat = '0;
    bus.cmd_sel = '0; bus.rsp_ready = 1'b0; bus.p_wb_DAT_I = '0;
    bus.p_wb_ACK_I = 1'b0; bus.p_wb_ERR_I = 1'b0; bus.p_wb_RTY_I = 1'b0;

    // Reset state, with a pending request that must not be taken early
    bus.cmd_valid = 1'b1;
    #12;
    chk1("rst_cyc", bus.p_wb_CYC_O, 1'b0);
    chk1("rst_stb", bus.p_wb_STB_O, 1'b0);
    chk1("rst_we", bus.p_wb_WE_O, 1'b0);
    chk("rst_adr", bus.p_wb_ADR_O, 32'h0);
    chk("rst_dat", bus.p_wb_DAT_O, 32'h0);
    chk("rst_sel", 32'(bus.p_wb_SEL_O), 32'h0);
    chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_dat", bus.rsp_dat, 32'h0);
    chk("rst_rsp_code", 32'(bus.rsp_code), 32'd0);
    chk1("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk1("lock", bus.p_wb_LOCK_O, 1'b0);
    #10;
    p_resetn = 1'b1;
    step();
    chk1("first_edge_no_accept", bus.p_wb_STB_O, 1'b0);
    chk1("first_edge_ready", bus.cmd_ready, 1'b1);

    // Write, zero-wait ACK
    send_cmd(1'b1, 32'hb000_0004, 32'hDEAD_BEEF, 4'hF);
    chk1("wr_cyc", bus.p_wb_CYC_O, 1'b1);
    chk1("wr_stb", bus.p_wb_STB_O, 1'b1);
    chk1("wr_we", bus.p_wb_WE_O, 1'b1);
    chk("wr_adr", bus.p_wb_ADR_O, 32'hb000_0004);
    chk("wr_dat", bus.p_wb_DAT_O, 32'hDEAD_BEEF);
    chk("wr_sel", 32'(bus.p_wb_SEL_O), 32'hF);
    chk1("wr_busy_not_ready", bus.cmd_ready, 1'b0);
    chk1("wr_no_rsp_yet", bus.rsp_valid, 1'b0);
    bus.p_wb_ACK_I = 1'b1;
    step();
    bus.p_wb_ACK_I = 1'b0;
    chk1("wr_stb_drop", bus.p_wb_STB_O, 1'b0);
    chk1("wr_cyc_drop", bus.p_wb_CYC_O, 1'b0);
    chk1("wr_rsp_valid", bus.rsp_valid, 1'b1);
    chk("wr_rsp_code", 32'(bus.rsp_code), 32'd0);
    chk("wr_rsp_dat", bus.rsp_dat, 32'h0);
    release_rsp("wr");

    // Read, three wait states, then response held with rsp_ready low
    send_cmd(1'b0, 32'hb000_0000, 32'h0, 4'hF);
    chk1("rd_stb0", bus.p_wb_STB_O, 1'b1);
    chk1("rd_we", bus.p_wb_WE_O, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("rd_stb_wait", bus.p_wb_STB_O, 1'b1);
      chk("rd_adr_stable", bus.p_wb_ADR_O, 32'hb000_0000);
      chk1("rd_wait_no_rsp", bus.rsp_valid, 1'b0);
    end
    bus.p_wb_ACK_I = 1'b1;
    bus.p_wb_DAT_I = 32'h1234_5678;
    step();
    bus.p_wb_ACK_I = 1'b0;
    bus.p_wb_DAT_I = 32'hFFFF_FFFF;
    bus.p_wb_ERR_I = 1'b1;
    chk1("rd_stb_drop", bus.p_wb_STB_O, 1'b0);
    chk1("rd_rsp_valid", bus.rsp_valid, 1'b1);
    chk("rd_rsp_dat", bus.rsp_dat, 32'h1234_5678);
    chk("rd_rsp_code", 32'(bus.rsp_code), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("hold_rsp_valid", bus.rsp_valid, 1'b1);
      chk("hold_rsp_dat", bus.rsp_dat, 32'h1234_5678);
      chk("hold_rsp_code", 32'(bus.rsp_code), 32'd0);
      chk1("hold_cmd_ready", bus.cmd_ready, 1'b0);
      chk1("hold_cyc_idle", bus.p_wb_CYC_O, 1'b0);
    end
    bus.p_wb_ERR_I = 1'b0;
    release_rsp("rd");
    bus.p_wb_ACK_I = 1'b1;
    step();
    bus.p_wb_ACK_I = 1'b0;
    chk1("idle_ack_ignored", bus.rsp_valid, 1'b0);

    // RTY twice then ACK: STB 1,0,1,0,1 then done
    send_cmd(1'b1, 32'hb000_0010, 32'h0000_00A5, 4'h1);
    bus.p_wb_RTY_I = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk1("rty2_stb_pattern", bus.p_wb_STB_O, (i % 2) == 0);
      chk1("rty2_cyc_pattern", bus.p_wb_CYC_O, (i % 2) == 0);
      chk("rty2_adr", bus.p_wb_ADR_O, 32'hb000_0010);
      if (i == 4) begin
        bus.p_wb_RTY_I = 1'b0;
        bus.p_wb_ACK_I = 1'b1;
      end
      step();
    end
    bus.p_wb_ACK_I = 1'b0;
    chk1("rty2_stb_drop", bus.p_wb_STB_O, 1'b0);
    chk1("rty2_rsp_valid", bus.rsp_valid, 1'b1);
    chk("rty2_rsp_code", 32'(bus.rsp_code), 32'd0);
    release_rsp("rty2");

    // RTY forever: four attempts then RETRY_EXHAUSTED
    send_cmd(1'b0, 32'hb000_0020, 32'h0, 4'hF);
    bus.p_wb_RTY_I = 1'b1;
    attempts = 0;
    for (int i = 0; i < 7; i++) begin
      chk1("rtyx_stb_pattern", bus.p_wb_STB_O, (i % 2) == 0);
      chk1("rtyx_no_rsp", bus.rsp_valid, 1'b0);
      if (bus.p_wb_STB_O) attempts++;
      step();
    end
    bus.p_wb_RTY_I = 1'b0;
    chk("rtyx_attempts", attempts, 32'd4);
    chk1("rtyx_stb_drop", bus.p_wb_STB_O, 1'b0);
    chk1("rtyx_rsp_valid", bus.rsp_valid, 1'b1);
    chk("rtyx_rsp_code", 32'(bus.rsp_code), 32'd3);
    release_rsp("rtyx");

    // Silent slave: STB high exactly 16 cycles
    send_cmd(1'b0, 32'hb000_0030, 32'h0, 4'hF);
    for (int i = 0; i < 15; i++) begin
      chk1("tmo_stb_high", bus.p_wb_STB_O, 1'b1);
      step();
    end
    chk1("tmo_stb_last", bus.p_wb_STB_O, 1'b1);
    chk1("tmo_no_rsp_yet", bus.rsp_valid, 1'b0);
    step();
    chk1("tmo_stb_drop", bus.p_wb_STB_O, 1'b0);
    chk1("tmo_rsp_valid", bus.rsp_valid, 1'b1);
    chk("tmo_rsp_code", 32'(bus.rsp_code), 32'd2);
    release_rsp("tmo");

    // ACK and ERR together: ERR wins
    send_cmd(1'b0, 32'hb000_0040, 32'h0, 4'hF);
    bus.p_wb_ACK_I = 1'b1;
    bus.p_wb_ERR_I = 1'b1;
    bus.p_wb_RTY_I = 1'b1;
    step();
    bus.p_wb_ACK_I = 1'b0;
    bus.p_wb_ERR_I = 1'b0;
    bus.p_wb_RTY_I = 1'b0;
    chk1("err_stb_drop", bus.p_wb_STB_O, 1'b0);
    chk1("err_rsp_valid", bus.rsp_valid, 1'b1);
    chk("err_rsp_code", 32'(bus.rsp_code), 32'd1);
    release_rsp("err");

    // Reset pulse during BUS: immediate drop, no response, then normal write
    send_cmd(1'b1, 32'hb000_0050, 32'h5555_AAAA, 4'h3);
    chk1("rstmid_stb_before", bus.p_wb_STB_O, 1'b1);
    #2;
    p_resetn = 1'b0;
    #1;
    chk1("rstmid_cyc_async", bus.p_wb_CYC_O, 1'b0);
    chk1("rstmid_stb_async", bus.p_wb_STB_O, 1'b0);
    chk("rstmid_adr_async", bus.p_wb_ADR_O, 32'h0);
    chk1("rstmid_cmd_ready", bus.cmd_ready, 1'b0);
    @(posedge p_clk);
    #3;
    p_resetn = 1'b1;
    step();
    chk1("rstmid_no_rsp", bus.rsp_valid, 1'b0);
    chk1("rstmid_ready", bus.cmd_ready, 1'b1);
    send_cmd(1'b1, 32'hb000_0060, 32'h0BAD_F00D, 4'hC);
    chk("post_rst_adr", bus.p_wb_ADR_O, 32'hb000_0060);
    chk("post_rst_sel", 32'(bus.p_wb_SEL_O), 32'hC);
    bus.p_wb_ACK_I = 1'b1;
    step();
    bus.p_wb_ACK_I = 1'b0;
    chk1("post_rst_rsp_valid", bus.rsp_valid, 1'b1);
    chk("post_rst_rsp_code", 32'(bus.rsp_code), 32'd0);
    release_rsp("post_rst");
    chk1("lock_end", bus.p_wb_LOCK_O, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
